ascii_uart_tx: RTL and testbench
================================

ASCII_UART_TX -- requirements
Module: ascii_uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 87, clock cycles per UART bit (10 MHz / 115200 baud); legal range 2..4095.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, number of buffered characters; power of two only.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-high.
REQ-005 in_data  input  8  ASCII character from the upstream string-sequencer stage.
REQ-006 in_valid  input  1  in_data holds a character to transfer.
REQ-007 in_ready  output  1  block can accept a character this cycle.
REQ-008 tx  output  1  serial line, 8N1, idle high; registered.
REQ-009 busy  output  1  high while a frame is on the line or the FIFO is non-empty.
REQ-010 fifo_count  output  $clog2(FIFO_DEPTH)+1  characters currently buffered.
REQ-011 tx_done  output  1  one-cycle pulse at the end of each stop bit.

Function
REQ-012 Character SHALL be accepted on a rising edge where in_valid and in_ready are both 1; no other transfers.
REQ-013 in_ready SHALL be (fifo_count < FIFO_DEPTH), from registered count only; no same-cycle pop bypass when full.
REQ-014 FIFO SHALL be first-in-first-out, circular read/write pointers, wrap modulo FIFO_DEPTH.
REQ-015 Simultaneous push and pop SHALL leave fifo_count unchanged and preserve order.
REQ-016 Serializer FSM SHALL have states IDLE, START, DATA, STOP.
REQ-017 IDLE: if FIFO non-empty, pop head into 8-bit shift register, reset bit counter, go START; else stay, tx=1.
REQ-018 START: tx=0 for exactly CLKS_PER_BIT cycles, then DATA.
REQ-019 DATA: 8 bits LSB first, each held CLKS_PER_BIT cycles; after bit 7, go STOP.
REQ-020 STOP: tx=1 for CLKS_PER_BIT cycles; on final cycle assert tx_done for 1 cycle.
REQ-021 End of STOP: FIFO non-empty -> pop and go directly to START (no idle bit between frames); else IDLE.
REQ-022 Latency: character accepted into empty FIFO with FSM in IDLE at edge N -> tx falls at edge N+2.
REQ-023 Frame length SHALL be exactly 10*CLKS_PER_BIT cycles; baud counter width $clog2(CLKS_PER_BIT).
REQ-024 busy SHALL be (state != IDLE) or (fifo_count != 0).
REQ-025 in_valid while in_ready=0 SHALL be ignored and the character not stored; upstream holds it.

Reset
REQ-026 While rst_n=1: tx=1, tx_done=0, busy=0, fifo_count=0, in_ready=1, FSM=IDLE, pointers=0, baud and bit counters=0.
REQ-027 Assertion mid-frame SHALL abort the frame immediately (tx=1 asynchronously) and flush the FIFO; no partial frame resumes after release.
REQ-028 First accept possible on the first rising edge after rst_n deasserts.

Verification (bench uses CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-029 Reset: rst_n=1 mid-frame -> tx=1 same cycle, fifo_count=0, in_ready=1, busy=0.
REQ-030 Single char: push 0x54 ('T') into idle block -> tx low 2 edges later; line sequence 0,0,0,1,0,1,0,1,0,1 at 4 cycles/bit; tx_done pulses once at cycle 40.
REQ-031 Back-to-back: push "Fuego" (0x46,0x75,0x65,0x67,0x6F) with in_valid held -> 5 frames, no idle gap, 200 cycles of line activity, bytes decoded in order, 5 tx_done pulses.
REQ-032 Full FIFO: hold in_valid with 6 chars during first frame -> in_ready drops when fifo_count=4 and rises the cycle after a pop; no character lost or duplicated.
REQ-033 Simultaneous push/pop at fifo_count=1 at end of STOP -> fifo_count stays 1; next frame carries older character.
REQ-034 in_valid pulsed while in_ready=0 -> fifo_count unchanged; character absent from line output.

Source files
------------

// File: rtl/ascii_uart_tx.sv
// ASCII character UART transmitter: small FIFO in front of an 8N1 serializer.
// tx and tx_done are registered, so the line trails the FSM state by one cycle.
module ascii_uart_tx #(
  parameter int CLKS_PER_BIT = 87,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [7:0]                   in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic                         tx,
  output logic                         busy,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
  output logic                         tx_done
);

  localparam int CNT_W  = $clog2(CLKS_PER_BIT);
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNTF_W = $clog2(FIFO_DEPTH) + 1;

  localparam logic [CNT_W-1:0]  BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  BAUD_ZERO = {CNT_W{1'b0}};
  localparam logic [CNTF_W-1:0] FIFO_FULL = CNTF_W'(FIFO_DEPTH);
  localparam logic [CNTF_W-1:0] FIFO_ZERO = {CNTF_W{1'b0}};
  localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [PTR_W-1:0]  PTR_ZERO  = {PTR_W{1'b0}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t              state_r, state_s;
  logic [CNT_W-1:0]    baud_r, baud_s;
  logic [2:0]          bit_r, bit_s;
  logic [7:0]          shift_r, shift_s;
  logic [7:0]          mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_r, rd_ptr_r;
  logic [CNTF_W-1:0]   count_r, count_s;
  logic                push_s, pop_s, tx_s, done_s;
  logic                tx_r, done_r, busy_r, ready_r;
  logic [7:0]          head_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_LAST) ? PTR_ZERO : ptr + PTR_W'(1);
  endfunction

  assign push_s     = in_valid & ready_r;
  assign head_s     = mem_r[rd_ptr_r];
  assign in_ready   = ready_r;
  assign tx         = tx_r;
  assign tx_done    = done_r;
  assign busy       = busy_r;
  assign fifo_count = count_r;

  // FIFO storage; flushing is done through the pointers, not the array
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= in_data;
    end
  end

  // occupancy after this cycle's push/pop; a simultaneous pair cancels
  always_comb begin
    count_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_s = count_r + CNTF_W'(1);
      2'b01:   count_s = count_r - CNTF_W'(1);
      default: count_s = count_r;
    endcase
  end

  // serializer next-state, line level and done pulse
  always_comb begin
    state_s = state_r;
    baud_s  = baud_r;
    bit_s   = bit_r;
    shift_s = shift_r;
    pop_s   = 1'b0;
    done_s  = 1'b0;
    tx_s    = 1'b1;
    case (state_r)
      IDLE: begin
        baud_s = BAUD_ZERO;
        if (count_r != FIFO_ZERO) begin
          pop_s   = 1'b1;
          shift_s = head_s;
          bit_s   = 3'd0;
          state_s = START;
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        tx_s = 1'b0;
        if (baud_r == BAUD_LAST) begin
          baud_s  = BAUD_ZERO;
          state_s = DATA;
        end else begin
          baud_s = baud_r + CNT_W'(1);
        end
      end
      DATA: begin
        tx_s = shift_r[0];
        if (baud_r == BAUD_LAST) begin
          baud_s  = BAUD_ZERO;
          shift_s = {1'b0, shift_r[7:1]};
          if (bit_r == 3'd7) begin
            bit_s   = 3'd0;
            state_s = STOP;
          end else begin
            bit_s = bit_r + 3'd1;
          end
        end else begin
          baud_s = baud_r + CNT_W'(1);
        end
      end
      STOP: begin
        tx_s = 1'b1;
        if (baud_r == BAUD_LAST) begin
          baud_s = BAUD_ZERO;
          done_s = 1'b1;
          // chain straight into the next frame when more data is waiting
          if (count_r != FIFO_ZERO) begin
            pop_s   = 1'b1;
            shift_s = head_s;
            bit_s   = 3'd0;
            state_s = START;
          end else begin
            state_s = IDLE;
          end
        end else begin
          baud_s = baud_r + CNT_W'(1);
        end
      end
      default: begin
        state_s = IDLE;
        baud_s  = BAUD_ZERO;
        bit_s   = 3'd0;
      end
    endcase
  end

  // state, FIFO bookkeeping and registered outputs
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_r  <= IDLE;
      baud_r   <= BAUD_ZERO;
      bit_r    <= 3'd0;
      shift_r  <= 8'h00;
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= FIFO_ZERO;
      tx_r     <= 1'b1;
      done_r   <= 1'b0;
      busy_r   <= 1'b0;
      ready_r  <= 1'b1;
    end else begin
      state_r  <= state_s;
      baud_r   <= baud_s;
      bit_r    <= bit_s;
      shift_r  <= shift_s;
      wr_ptr_r <= push_s ? ptr_inc(wr_ptr_r) : wr_ptr_r;
      rd_ptr_r <= pop_s ? ptr_inc(rd_ptr_r) : rd_ptr_r;
      count_r  <= count_s;
      tx_r     <= tx_s;
      done_r   <= done_s;
      busy_r   <= (state_s != IDLE) || (count_s != FIFO_ZERO);
      ready_r  <= (count_s < FIFO_FULL);
    end
  end

endmodule

// File: tb/tb_ascii_uart_tx.sv
// Directed bench for ascii_uart_tx (4 clocks/bit, 4-deep FIFO); a line monitor
// captures 40-sample frames which are compared with hand-computed bit patterns.
module tb_ascii_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b1;
  logic [7:0] in_data  = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready, tx, busy, tx_done;
  logic [2:0] fifo_count;

  ascii_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .tx         (tx),
    .busy       (busy),
    .fifo_count (fifo_count),
    .tx_done    (tx_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [0:39] samp;
    int          start;
    logic        done;
  } frame_t;

  typedef struct {
    logic [7:0] ch;
    logic [0:9] line;
  } vec_t;

  frame_t     frames[$];
  frame_t     cur;
  int         mon_off    = 0;
  logic       mon_active = 1'b0;
  int         done_cnt   = 0;
  vec_t       vecs[6];
  logic [7:0] push_q[$];
  int         acc_q[$];
  int         log_cyc[$];
  logic [2:0] log_cnt[$];
  logic       log_rdy[$];

  // line monitor: a falling edge starts a 40-sample frame capture
  always @(negedge clk) begin
    if (rst_n) begin
      mon_active = 1'b0;
    end else if (mon_active) begin
      cur.samp[mon_off] = tx;
      if (mon_off == 39) begin
        cur.done = tx_done;
        frames.push_back(cur);
        mon_active = 1'b0;
      end else begin
        mon_off = mon_off + 1;
      end
    end else if (tx == 1'b0) begin
      mon_active = 1'b1;
      cur.start = cyc;
      cur.samp = '1;
      cur.samp[0] = tx;
      mon_off = 1;
    end
    if (!rst_n && tx_done) done_cnt = done_cnt + 1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [0:39] expand(input logic [0:9] l);
    logic [0:39] r;
    for (int k = 0; k < 40; k++) r[k] = l[k/4];
    return r;
  endfunction

  function automatic logic [7:0] decode(input logic [0:39] s);
    logic [7:0] b;
    for (int k = 0; k < 8; k++) b[k] = s[4*(k+1)+2];
    return b;
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // offer push_q in order with in_valid held; called and returns at a negedge
  task automatic push_all();
    int   idx = 0;
    int   guard = 0;
    logic acc;
    acc_q.delete();
    log_cyc.delete();
    log_cnt.delete();
    log_rdy.delete();
    while (idx < push_q.size() && guard < 500) begin
      in_data  = push_q[idx];
      in_valid = 1'b1;
      acc      = in_ready;
      @(negedge clk);
      guard++;
      log_cyc.push_back(cyc);
      log_cnt.push_back(fifo_count);
      log_rdy.push_back(in_ready);
      if (acc) begin
        acc_q.push_back(cyc);
        idx++;
      end
    end
    in_valid = 1'b0;
    chk("push_timeout", 64'(idx), 64'(push_q.size()));
  endtask

  task automatic chk_at(input string name, input int c, input logic [2:0] ecnt, input logic erdy);
    int hit = 0;
    foreach (log_cyc[k]) begin
      if (log_cyc[k] == c) begin
        hit = 1;
        chk({name, "_cnt"}, 64'(log_cnt[k]), 64'(ecnt));
        chk({name, "_rdy"}, 64'(log_rdy[k]), 64'(erdy));
      end
    end
    chk({name, "_logged"}, 64'(hit), 64'd1);
  endtask

  task automatic chk_decoded(input string name, input logic [7:0] exp_q[$]);
    chk({name, "_nframes"}, 64'(frames.size()), 64'(exp_q.size()));
    for (int k = 0; k < exp_q.size() && k < frames.size(); k++) begin
      chk($sformatf("%s_byte%0d", name, k), 64'(decode(frames[k].samp)), 64'(exp_q[k]));
      if (k > 0) chk($sformatf("%s_gap%0d", name, k), 64'(frames[k].start - frames[k-1].start), 64'd40);
    end
  endtask

  initial begin
    logic [7:0] exp_q[$];
    int         base;
    int         guard;

    vecs[0] = '{ch: 8'h54, line: 10'b0001010101};
    vecs[1] = '{ch: 8'h46, line: 10'b0011000101};
    vecs[2] = '{ch: 8'h75, line: 10'b0101011101};
    vecs[3] = '{ch: 8'h65, line: 10'b0101001101};
    vecs[4] = '{ch: 8'h67, line: 10'b0111001101};
    vecs[5] = '{ch: 8'h6F, line: 10'b0111101101};

    // reset values
    wait_cycles(3);
    chk("reset_tx", 64'(tx), 64'd1);
    chk("reset_ready", 64'(in_ready), 64'd1);
    chk("reset_count", 64'(fifo_count), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(tx_done), 64'd0);
    rst_n = 1'b0;
    wait_cycles(2);

    // single characters into an idle block
    for (int i = 0; i < 6; i++) begin
      frames.delete();
      done_cnt = 0;
      push_q = '{vecs[i].ch};
      push_all();
      chk($sformatf("single%0d_count_n", i), 64'(fifo_count), 64'd1);
      chk($sformatf("single%0d_busy", i), 64'(busy), 64'd1);
      chk($sformatf("single%0d_tx_n", i), 64'(tx), 64'd1);
      wait_cycles(1);
      chk($sformatf("single%0d_tx_n1", i), 64'(tx), 64'd1);
      wait_cycles(1);
      chk($sformatf("single%0d_tx_n2", i), 64'(tx), 64'd0);
      wait_cycles(45);
      chk($sformatf("single%0d_nframes", i), 64'(frames.size()), 64'd1);
      if (frames.size() > 0) begin
        chk($sformatf("single%0d_line", i), 64'(frames[0].samp), 64'(expand(vecs[i].line)));
        chk($sformatf("single%0d_done40", i), 64'(frames[0].done), 64'd1);
        chk($sformatf("single%0d_latency", i), 64'(frames[0].start - acc_q[0]), 64'd2);
      end
      chk($sformatf("single%0d_ndone", i), 64'(done_cnt), 64'd1);
      chk($sformatf("single%0d_idle_busy", i), 64'(busy), 64'd0);
    end

    // "Fuego" back to back
    frames.delete();
    done_cnt = 0;
    push_q.delete();
    for (int k = 1; k < 6; k++) push_q.push_back(vecs[k].ch);
    push_all();
    wait_cycles(215);
    chk("fuego_nframes", 64'(frames.size()), 64'd5);
    for (int k = 0; k < 5 && k < frames.size(); k++) begin
      chk($sformatf("fuego_line%0d", k), 64'(frames[k].samp), 64'(expand(vecs[k+1].line)));
      chk($sformatf("fuego_done%0d", k), 64'(frames[k].done), 64'd1);
    end
    if (frames.size() == 5) chk("fuego_span", 64'(frames[4].start + 40 - frames[0].start), 64'd200);
    chk("fuego_ndone", 64'(done_cnt), 64'd5);

    // six characters against a 4-deep FIFO
    frames.delete();
    done_cnt = 0;
    push_q = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46};
    push_all();
    base = acc_q[0];
    exp_q = '{0, 1, 2, 3, 4, 42};
    for (int k = 1; k < 6 && k < acc_q.size(); k++)
      chk($sformatf("full_accept%0d", k), 64'(acc_q[k] - base), 64'(exp_q[k]));
    chk_at("full_n4", base + 4, 3'd4, 1'b0);
    chk_at("full_n40", base + 40, 3'd4, 1'b0);
    chk_at("full_n41", base + 41, 3'd3, 1'b1);
    chk_at("full_n42", base + 42, 3'd4, 1'b0);
    wait_cycles(260);
    chk_decoded("full", push_q);
    chk("full_ndone", 64'(done_cnt), 64'd6);

    // push coinciding with the end-of-stop pop at fifo_count=1
    frames.delete();
    push_q = '{8'h31, 8'h32};
    push_all();
    base = acc_q[0];
    guard = 0;
    while (cyc < base + 40 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("simul_pre_count", 64'(fifo_count), 64'd1);
    chk("simul_pre_ready", 64'(in_ready), 64'd1);
    in_data  = 8'h33;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("simul_count", 64'(fifo_count), 64'd1);
    wait_cycles(130);
    exp_q = '{8'h31, 8'h32, 8'h33};
    chk_decoded("simul", exp_q);

    // in_valid while full is ignored
    frames.delete();
    push_q = '{8'h50, 8'h51, 8'h52, 8'h53, 8'h54};
    push_all();
    chk("ign_ready", 64'(in_ready), 64'd0);
    in_data  = 8'h57;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("ign_count", 64'(fifo_count), 64'd4);
    wait_cycles(220);
    chk_decoded("ign", push_q);

    // reset in the middle of a frame, then accept right after release
    frames.delete();
    push_q = '{8'h00, 8'h41, 8'h42};
    push_all();
    wait_cycles(10);
    chk("mid_pre_tx", 64'(tx), 64'd0);
    #2 rst_n = 1'b1;
    #1;
    chk("mid_tx", 64'(tx), 64'd1);
    chk("mid_count", 64'(fifo_count), 64'd0);
    chk("mid_ready", 64'(in_ready), 64'd1);
    chk("mid_busy", 64'(busy), 64'd0);
    chk("mid_done", 64'(tx_done), 64'd0);
    wait_cycles(2);
    frames.delete();
    done_cnt = 0;
    rst_n    = 1'b0;
    in_data  = 8'h54;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("first_accept", 64'(fifo_count), 64'd1);
    wait_cycles(50);
    exp_q = '{8'h54};
    chk_decoded("post_reset", exp_q);
    chk("post_reset_ndone", 64'(done_cnt), 64'd1);
    chk("post_reset_tx", 64'(tx), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
